// File: rtl/fabric_cfg_pkg.sv
// Shared constants and state encoding for the fabric configuration path.
// Holds the bitstream control words, the header tag and the sequencer state enum.
package fabric_cfg_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
    localparam logic [7:0]  HEADER_TAG  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_STROBE,
        ST_GUARD
    } seq_state_e;

    function automatic logic has_header_tag(input logic [31:0] word);
        return word[31:24] == HEADER_TAG;
    endfunction

    // States in which the sequencer takes words from the stream.
    function automatic logic accepts_words(input seq_state_e state);
        return (state == ST_IDLE) || (state == ST_HEADER) || (state == ST_DATA);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Index-to-one-hot decoder for the per-column frame latch strobes.
// An out-of-range index or a low enable yields an all-zero vector.
module frame_strobe_decoder #(
    parameter int Width = 20,
    parameter int IdxW  = 5
) (
    input  logic [IdxW-1:0]  index,
    input  logic             enable,
    output logic [Width-1:0] onehot
);

    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this
        // block purely combinational; leaving a path unassigned infers a latch.
        onehot = '0;
        if (enable) begin
            for (int i = 0; i < Width; i++) begin
                if (index == IdxW'(i)) begin
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-driven frame sequencer: SYNC, header, NumRows data words, then a
// one-cycle one-hot strobe and a guard cycle before the next header.
module frame_config_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4
) (
    input  logic                                 UserCLK,
    input  logic                                 Reset,
    input  logic [FrameBitsPerRow-1:0]           s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 error
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
    localparam logic [31:0] MaxIdx = 32'(MaxFramesPerCol);

    seq_state_e                           state_q, state_d;
    logic [RowW-1:0]                      row_q;
    logic [IdxW-1:0]                      index_q;
    logic [FrameBitsPerRow*NumRows-1:0]   data_q;
    logic [MaxFramesPerCol-1:0]           strobe_q, strobe_d;
    logic                                 ready_q, busy_q, done_q, error_q;

    logic [31:0] word;
    logic        accept;
    logic        hdr_ok;
    logic        hdr_err;
    logic        last_word;

    assign word      = s_data[31:0];
    assign accept    = s_valid && ready_q;
    assign hdr_ok    = has_header_tag(word) && ({24'd0, word[7:0]} < MaxIdx);
    assign last_word = (state_q == ST_DATA) && accept && (row_q == LastRow);
    assign hdr_err   = (state_q == ST_HEADER) && accept &&
                       (word != DESYNC_WORD) && !hdr_ok;

    // Strobe is decoded one cycle early so it can be registered into STROBE.
    frame_strobe_decoder #(
        .Width (MaxFramesPerCol),
        .IdxW  (IdxW)
    ) u_strobe_dec (
        .index  (index_q),
        .enable (last_word),
        .onehot (strobe_d)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (word == SYNC_WORD)) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (accept) begin
                    if (word == DESYNC_WORD) state_d = ST_IDLE;
                    else if (hdr_ok)         state_d = ST_DATA;
                    else                     state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (last_word) state_d = ST_STROBE;
            end
            ST_STROBE: state_d = ST_GUARD;
            ST_GUARD:  state_d = ST_HEADER;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        // NOTE: non-blocking assignments make every register below sample the
        // pre-edge values, so statement order inside this block does not matter.
        if (Reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            index_q  <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            ready_q  <= accepts_words(state_d);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_q == ST_STROBE);

            if (hdr_err) error_q <= 1'b1;

            if ((state_q == ST_HEADER) && accept && hdr_ok) begin
                index_q <= word[IdxW-1:0];
                row_q   <= '0;
            end

            if ((state_q == ST_DATA) && accept) begin
                for (int r = 0; r < NumRows; r++) begin
                    if (row_q == RowW'(r)) begin
                        data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                    end
                end
                row_q <= (row_q == LastRow) ? '0 : row_q + RowW'(1);
            end
        end
    end

    assign s_ready     = ready_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Randomised scoreboard bench for frame_config_sequencer: a stream-level model
// predicts each committed frame, a monitor checks strobe, data and guard timing.
module tb_frame_config_sequencer;

    localparam int FB = 32;
    localparam int MF = 20;
    localparam int NR = 4;
    localparam int DW = FB * NR;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic          UserCLK;
    logic          Reset;
    logic [FB-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] FrameData;
    logic [MF-1:0] FrameStrobe;
    logic          busy;
    logic          frame_done;
    logic          error;

    frame_config_sequencer #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .NumRows         (NR)
    ) dut (
        .UserCLK     (UserCLK),
        .Reset       (Reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .frame_done  (frame_done),
        .error       (error)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int gap_pct  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream-level reference model: tracks only sync/header/data phases.
    typedef enum {M_IDLE, M_HDR, M_DATA} mmode_e;
    typedef struct {
        logic [MF-1:0] strobe;
        logic [DW-1:0] data;
    } exp_t;

    mmode_e      m_mode = M_IDLE;
    int          m_idx  = 0;
    bit          m_err  = 1'b0;
    logic [31:0] m_rows[$];
    exp_t        exp_q[$];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_err  = 1'b0;
        m_rows.delete();
    endtask

    task automatic model_accept(input logic [31:0] w);
        exp_t e;
        case (m_mode)
            M_IDLE: if (w == SYNC) m_mode = M_HDR;
            M_HDR: begin
                if (w == DESYNC) begin
                    m_mode = M_IDLE;
                end else if (w[31:24] == 8'hA5 && int'(w[7:0]) < MF) begin
                    m_idx  = int'(w[7:0]);
                    m_rows.delete();
                    m_mode = M_DATA;
                end else begin
                    m_err  = 1'b1;
                    m_mode = M_IDLE;
                end
            end
            M_DATA: begin
                m_rows.push_back(w);
                if (m_rows.size() == NR) begin
                    e.strobe = '0;
                    e.strobe[m_idx] = 1'b1;
                    e.data = '0;
                    for (int r = 0; r < NR; r++) e.data[r*FB +: FB] = m_rows[r];
                    exp_q.push_back(e);
                    m_mode = M_HDR;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic send_word(input logic [31:0] w);
        bit done = 1'b0;
        int cyc  = 0;
        while (!done) begin
            @(negedge UserCLK);
            check("busy", DW'(busy), DW'(m_mode != M_IDLE));
            if (cyc > 200) begin
                check("send_timeout", DW'(1), DW'(0));
                s_valid = 1'b0;
                done = 1'b1;
            end else if ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end else begin
                s_valid = 1'b1;
                s_data  = w;
                if (s_ready) begin
                    model_accept(w);
                    done = 1'b1;
                end
            end
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge UserCLK);
            s_valid = 1'b0;
            s_data  = $urandom;
        end
    endtask

    function automatic logic [31:0] header(input int idx);
        logic [15:0] mid;
        mid = 16'($urandom);
        return {8'hA5, mid, 8'(idx)};
    endfunction

    task automatic send_frame(input int idx);
        send_word(header(idx));
        for (int r = 0; r < NR; r++) send_word($urandom);
    endtask

    task automatic check_reset_state();
        check("rst_framedata", FrameData, '0);
        check("rst_strobe", DW'(FrameStrobe), '0);
        check("rst_ready", DW'(s_ready), DW'(1));
        check("rst_busy", DW'(busy), '0);
        check("rst_done", DW'(frame_done), '0);
        check("rst_error", DW'(error), '0);
    endtask

    task automatic do_reset();
        @(negedge UserCLK);
        Reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge UserCLK);
        Reset = 1'b0;
        model_reset();
        check_reset_state();
    endtask

    // Monitor: pops an expected frame whenever a strobe appears, then checks
    // the guard cycle and the return of s_ready.
    initial begin
        logic [DW-1:0] held;
        bit in_guard    = 1'b0;
        bit after_guard = 1'b0;
        exp_t e;
        held = '0;
        forever begin
            @(negedge UserCLK);
            if (in_guard) begin
                check("guard_done", DW'(frame_done), DW'(1));
                check("guard_strobe", DW'(FrameStrobe), '0);
                check("guard_data", FrameData, held);
                check("guard_ready", DW'(s_ready), '0);
                in_guard    = 1'b0;
                after_guard = 1'b1;
            end else begin
                if (after_guard) begin
                    check("post_guard_ready", DW'(s_ready), DW'(1));
                    after_guard = 1'b0;
                end
                if (frame_done) check("spurious_done", DW'(frame_done), '0);
                if (FrameStrobe != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", DW'(FrameStrobe), '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe", DW'(FrameStrobe), DW'(e.strobe));
                        check("framedata", FrameData, e.data);
                        check("strobe_ready", DW'(s_ready), '0);
                    end
                    held     = FrameData;
                    in_guard = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] junk;
        Reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge UserCLK);
        Reset = 1'b0;
        model_reset();
        check_reset_state();

        // Reference frame: index 3, rows 0x11.. to 0x44..
        send_word(SYNC);
        send_word(32'hA500_0003);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        idle(4);
        check("framedata_known", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("no_error_1", DW'(error), DW'(m_err));

        send_word(DESYNC);
        idle(2);
        check("desync_busy", DW'(busy), '0);

        // Back-to-back frames at the two extreme indices after one SYNC.
        send_word(SYNC);
        send_frame(0);
        send_frame(MF - 1);
        idle(4);

        // Out-of-range index: error, back to IDLE, no strobe.
        send_word(32'hA500_0014);
        idle(3);
        check("bad_idx_error", DW'(error), DW'(1));
        check("bad_idx_busy", DW'(busy), '0);
        send_word(SYNC);
        send_frame(7);
        idle(4);
        check("error_sticky", DW'(error), DW'(m_err));

        // Reset after two data words aborts the frame.
        do_reset();
        send_word(SYNC);
        send_word(header(2));
        send_word($urandom);
        send_word($urandom);
        do_reset();
        send_word(SYNC);
        send_frame(5);
        idle(4);

        // Reset coincident with the last data word wins over the strobe.
        send_word(SYNC);
        send_word(header(9));
        for (int r = 0; r < NR - 1; r++) send_word($urandom);
        @(negedge UserCLK);
        s_valid = 1'b1;
        s_data  = $urandom;
        Reset   = 1'b1;
        @(negedge UserCLK);
        Reset   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        check_reset_state();
        idle(3);

        // Random stream with ~50% valid gaps.
        gap_pct = 50;
        junk = $urandom;
        if (junk == SYNC) junk = junk ^ 32'h1;
        send_word(junk);
        idle(2);
        check("junk_no_error", DW'(error), '0);
        check("junk_idle", DW'(busy), '0);
        send_word(SYNC);
        for (int f = 0; f < 6; f++) send_frame(int'($urandom_range(MF - 1)));
        send_word(DESYNC);
        idle(4);
        check("final_busy", DW'(busy), '0);
        check("final_error", DW'(error), DW'(m_err));
        check("queue_drained", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
